// File: rtl/pinwheel_pkg.sv
// pinwheel_pkg: shared hart-state encoding and error-cause bit positions for the pinwheel hart scheduler
package pinwheel_pkg;
    typedef enum logic [1:0] {PARKED, READY, INFLIGHT, WAIT_BUS} hart_state_e;
    localparam int ERR_W           = 4;
    localparam int ERR_RET_STATE   = 0;
    localparam int ERR_D_STATE     = 1;
    localparam int ERR_START_STATE = 2;
    localparam int ERR_MISALIGN    = 3;
endpackage

// File: rtl/pinwheel_rr_pick.sv
// pinwheel_rr_pick: combinational round-robin picker, first set ready bit after ptr with wrap
module pinwheel_rr_pick #(
    parameter int N = 8,
    parameter int B = $clog2(N)
) (
    input  logic [N-1:0] ready,
    input  logic [B-1:0] ptr,
    output logic         found,
    output logic [B-1:0] idx
);
    // scan farthest-to-nearest so the hart closest after ptr wins
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (ready[B'(int'(ptr) + i)]) begin
                found = 1'b1;
                idx = B'(int'(ptr) + i);
            end
        end
    end
endmodule

// File: rtl/pinwheel_hart_sched.sv
// pinwheel_hart_sched: per-hart PC/state storage with round-robin issue of ready harts to fetch
module pinwheel_hart_sched
    import pinwheel_pkg::*;
#(
    parameter int                  HART_COUNT = 8,
    parameter int                  HART_BITS  = $clog2(HART_COUNT),
    parameter int                  PC_WIDTH   = 24,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(24'h400000)
) (
    input  logic                  clock,
    input  logic                  tick_reset_in,
    output logic                  issue_valid,
    output logic [HART_BITS-1:0]  issue_hart,
    output logic [PC_WIDTH-1:0]   issue_pc,
    input  logic                  ret_valid,
    input  logic [HART_BITS-1:0]  ret_hart,
    input  logic [PC_WIDTH-1:0]   ret_next_pc,
    input  logic                  ret_park,
    input  logic                  ret_wait,
    input  logic                  bus_d_valid,
    input  logic [HART_BITS-1:0]  bus_d_source,
    input  logic                  start_valid,
    input  logic [HART_BITS-1:0]  start_hart,
    input  logic [PC_WIDTH-1:0]   start_pc,
    output logic [HART_COUNT-1:0] active_mask,
    output logic                  err_pulse,
    output logic [31:0]           stat_issued
);
    hart_state_e           st   [HART_COUNT];
    hart_state_e           st_n [HART_COUNT];
    logic [PC_WIDTH-1:0]   pc   [HART_COUNT];
    logic [PC_WIDTH-1:0]   pc_n [HART_COUNT];
    logic [HART_COUNT-1:0] ready;
    logic [HART_COUNT-1:0] active_n;
    logic [HART_BITS-1:0]  ptr;
    logic [HART_BITS-1:0]  pick;
    logic                  found;
    logic                  ret_ok;
    logic                  misaligned;
    logic                  d_merge;
    logic [ERR_W-1:0]      cause;

    assign ret_ok     = ret_valid && st[ret_hart] == INFLIGHT;
    assign misaligned = ret_next_pc[1:0] != 2'b00;
    // a wait-return meeting its own D beat in the same cycle consumes that beat
    assign d_merge    = ret_ok && ret_wait && !ret_park && !misaligned &&
                        bus_d_valid && bus_d_source == ret_hart;

    // ready vector for the picker
    always_comb begin
        for (int h = 0; h < HART_COUNT; h++) ready[h] = st[h] == READY;
    end

    pinwheel_rr_pick #(.N(HART_COUNT), .B(HART_BITS)) u_pick (
        .ready(ready),
        .ptr(ptr),
        .found(found),
        .idx(pick)
    );

    // next per-hart state/PC from issue, ret, D and start, all judged on pre-edge state
    always_comb begin
        cause = '0;
        for (int h = 0; h < HART_COUNT; h++) begin
            st_n[h] = (found && pick == HART_BITS'(h)) ? INFLIGHT : st[h];
            pc_n[h] = pc[h];
        end
        if (ret_valid && !ret_ok) cause[ERR_RET_STATE] = 1'b1;
        if (ret_ok) begin
            pc_n[ret_hart] = ret_next_pc;
            st_n[ret_hart] = (misaligned || ret_park) ? PARKED :
                             (ret_wait && !d_merge) ? WAIT_BUS : READY;
            cause[ERR_MISALIGN] = misaligned;
        end
        if (bus_d_valid && st[bus_d_source] == WAIT_BUS) st_n[bus_d_source] = READY;
        if (bus_d_valid && st[bus_d_source] != WAIT_BUS && !d_merge) cause[ERR_D_STATE] = 1'b1;
        if (start_valid && st[start_hart] == PARKED) begin
            st_n[start_hart] = READY;
            pc_n[start_hart] = start_pc;
        end
        if (start_valid && st[start_hart] != PARKED) cause[ERR_START_STATE] = 1'b1;
        for (int h = 0; h < HART_COUNT; h++) active_n[h] = st_n[h] != PARKED;
    end

    // state, pointer, registered issue outputs and counters
    always_ff @(posedge clock) begin
        if (tick_reset_in) begin
            for (int h = 0; h < HART_COUNT; h++) begin
                st[h] <= (h == 0) ? READY : PARKED;
                pc[h] <= (h == 0) ? RESET_PC : '0;
            end
            ptr         <= HART_BITS'(HART_COUNT - 1);
            issue_valid <= 1'b0;
            issue_hart  <= '0;
            issue_pc    <= '0;
            active_mask <= HART_COUNT'(1);
            err_pulse   <= 1'b0;
            stat_issued <= '0;
        end else begin
            for (int h = 0; h < HART_COUNT; h++) begin
                st[h] <= st_n[h];
                pc[h] <= pc_n[h];
            end
            ptr         <= found ? pick : ptr;
            issue_valid <= found;
            issue_hart  <= found ? pick : '0;
            issue_pc    <= found ? pc[pick] : '0;
            active_mask <= active_n;
            err_pulse   <= |cause;
            stat_issued <= stat_issued + 32'(issue_valid);
        end
    end
endmodule
